// File: rtl/sc_stream_decoder_if.sv
// sc_stream_decoder_if: handshake and result bundle for the stochastic stream decoder
//   start/scale3   request to begin a run and its scaling mode
//   bit_in/bit_valid serial stream bit and its qualifier
//   out_ready      consumer accepts the result
//   busy/out_valid status: run in progress / result presented
//   count/value    ones count and decoded magnitude
interface sc_stream_decoder_if #(
    parameter int CW = 7
);
    logic          start;
    logic          scale3;
    logic          bit_in;
    logic          bit_valid;
    logic          out_ready;
    logic          busy;
    logic          out_valid;
    logic [CW-1:0] count;
    logic [CW+1:0] value;

    modport master (
        output start, scale3, bit_in, bit_valid, out_ready,
        input  busy, out_valid, count, value
    );

    modport slave (
        input  start, scale3, bit_in, bit_valid, out_ready,
        output busy, out_valid, count, value
    );
endinterface

// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts ones over a LEN-bit stochastic stream and presents count and (optionally x3) value
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  sc_stream_decoder_if slave: start/scale3/bit_in/bit_valid/out_ready in, busy/out_valid/count/value out
module sc_stream_decoder #(
    parameter int LEN = 64,
    parameter int CW  = $clog2(LEN) + 1
) (
    input  logic                clk,
    input  logic                rst,
    sc_stream_decoder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t        r_state;
    logic [CW-1:0] r_ones;
    logic [CW-1:0] r_smp;
    logic          r_scale3;
    logic          r_busy;
    logic          r_valid;
    logic [CW-1:0] r_count;
    logic [CW+1:0] r_value;
    logic [CW-1:0] w_ones;
    logic [CW+1:0] w_value;
    logic          w_last;

    assign w_ones  = r_ones + {{(CW-1){1'b0}}, bus.bit_in};
    // x3 as (n<<1)+n in the widened domain so 3*LEN never truncates
    assign w_value = r_scale3 ? ({2'b00, w_ones} << 1) + {2'b00, w_ones} : {2'b00, w_ones};
    assign w_last  = r_smp == CW'(LEN - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ones   <= '0;
            r_smp    <= '0;
            r_scale3 <= 1'b0;
            r_busy   <= 1'b0;
            r_valid  <= 1'b0;
            r_count  <= '0;
            r_value  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_state  <= ACCUM;
                        r_ones   <= '0;
                        r_smp    <= '0;
                        r_scale3 <= bus.scale3;
                        r_busy   <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (bus.bit_valid) begin
                        r_ones <= w_ones;
                        r_smp  <= w_last ? '0 : r_smp + 1'b1;
                        if (w_last) begin
                            r_state <= HOLD;
                            r_count <= w_ones;
                            r_value <= w_value;
                            r_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        r_valid <= 1'b0;
                        // a start alongside the release goes straight into the next run
                        r_state <= bus.start ? ACCUM : IDLE;
                        r_busy  <= bus.start;
                        if (bus.start) begin
                            r_ones   <= '0;
                            r_smp    <= '0;
                            r_scale3 <= bus.scale3;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.out_valid = r_valid;
    assign bus.count     = r_count;
    assign bus.value     = r_value;
endmodule
